// File: rtl/rf_access_master_pkg.sv
// Shared definitions for the register-file access master.
//   state_e       : transaction FSM states
//   RSP_*         : encoding of rsp_status
//   TMO_CNT_W     : width of the WAIT-cycle timeout counter (TIMEOUT <= 255)
//   done_status() : status reported for a completed access
package rf_access_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [1:0] RSP_OK           = 2'd0;
  localparam logic [1:0] RSP_INVALID_ADDR = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT      = 2'd2;

  localparam int TMO_CNT_W = 8;

  function automatic logic [1:0] done_status(input logic invalid);
    return invalid ? RSP_INVALID_ADDR : RSP_OK;
  endfunction

endpackage

// File: rtl/rf_timeout_counter.sv
// Counts WAIT cycles of the current access and flags the cycle on which
// the TIMEOUT-th WAIT cycle is being spent.
//   clk     : clock, rising edge
//   res     : synchronous active-high reset
//   clr     : clear the count (asserted in the cycle before WAIT is entered)
//   inc     : advance the count (asserted in every WAIT cycle)
//   expired : this WAIT cycle is the TIMEOUT-th one
module rf_timeout_counter
  import rf_access_master_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TMO_CNT_W-1:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (res) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of WAIT cycles already completed.
  assign expired = (count_q == TMO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rf_access_master.sv
// Host-to-register-file access master. Accepts one read/write command at a
// time, issues a one-cycle strobe, waits for the responder's completion (or
// gives up after TIMEOUT WAIT cycles) and holds the response until taken.
//   clk, res                         : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : host command channel
//   rsp_valid/ready/rdata/status     : host response channel
//   address, read_en, write_en,
//   write_data                       : register-file request
//   read_data, invalid_address,
//   access_complete                  : register-file completion
module rf_access_master
  import rf_access_master_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-1:0] address,
  output logic              read_en,
  output logic              write_en,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data,
  input  logic              invalid_address,
  input  logic              access_complete
);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [31:0]         write_data_q, write_data_d;
  logic                read_en_q, read_en_d;
  logic                write_en_q, write_en_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_status_q, rsp_status_d;

  logic tmo_clr, tmo_inc, tmo_expired;

  // Clearing during STROBE makes the count start at zero on WAIT entry.
  assign tmo_clr = (state_q == ST_STROBE);
  assign tmo_inc = (state_q == ST_WAIT);

  rf_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .res     (res),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = 1'b0;
    write_d      = write_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    read_en_d    = 1'b0;
    write_en_d   = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d      = ST_STROBE;
          write_d      = cmd_write;
          address_d    = cmd_addr;
          write_data_d = cmd_wdata;
          // Strobes are registered, so they are high exactly during STROBE.
          read_en_d    = !cmd_write;
          write_en_d   = cmd_write;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_STROBE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is tested first so it wins on the expiry cycle.
        if (access_complete) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = done_status(invalid_address);
          rsp_rdata_d  = (!write_q && !invalid_address) ? read_data : '0;
        end else if (tmo_expired) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = RSP_TIMEOUT;
          rsp_rdata_d  = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= RSP_OK;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      write_q      <= write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      read_en_q    <= read_en_d;
      write_en_q   <= write_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign address    = address_q;
  assign write_data = write_data_q;
  assign read_en    = read_en_q;
  assign write_en   = write_en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_rf_access_master.sv
// Bench for rf_access_master. Stimulus issues commands and pushes the
// model's expected response to a scoreboard queue; a responder process acts
// as the register file; a monitor pops and compares responses.
module tb_rf_access_master;
  import rf_access_master_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int TMO      = 4;
  localparam int RF_DEPTH = 8;   // addresses 0..7 exist, the rest are invalid

  logic              clk = 1'b0;
  logic              res;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_status;
  logic [ADDR_W-1:0] address;
  logic              read_en, write_en;
  logic [31:0]       write_data, read_data;
  logic              invalid_address, access_complete;

  always #5 clk = ~clk;

  rf_access_master #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .res             (res),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_status      (rsp_status),
    .address         (address),
    .read_en         (read_en),
    .write_en        (write_en),
    .write_data      (write_data),
    .read_data       (read_data),
    .invalid_address (invalid_address),
    .access_complete (access_complete)
  );

  typedef struct {
    logic [1:0]  status;
    logic [31:0] rdata;
    int          wait_cyc;   // WAIT cycles before RESP
    int          bp;         // cycles the monitor withholds rsp_ready
  } exp_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    int                dly;       // responder completes dly cycles after strobe; 0 = never
    int                wait_cyc;
  } str_t;

  exp_t exp_q[$];
  str_t str_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_strobe_cyc = 0;
  logic inject_stray = 1'b0;
  logic [31:0] ref_mem [RF_DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h1234_5678 : (32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101));
  endfunction

  // Called at a negedge; returns one negedge after the command is accepted.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input int dly, input int bp, input bit expect_rsp);
    int   waited;
    bit   completes;
    exp_t e;
    str_t s;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      check("cmd_accept_wait", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    completes = (dly >= 1) && (dly <= TMO);
    e.wait_cyc = completes ? dly : TMO;
    e.bp       = bp;
    if (!completes) begin
      e.status = RSP_TIMEOUT;      e.rdata = '0;
    end else if (int'(addr) >= RF_DEPTH) begin
      e.status = RSP_INVALID_ADDR; e.rdata = '0;
    end else if (wr) begin
      e.status = RSP_OK;           e.rdata = '0;
    end else begin
      e.status = RSP_OK;           e.rdata = ref_mem[addr[2:0]];
    end
    // The register file performs the access whenever it answers, even late.
    if (dly != 0 && int'(addr) < RF_DEPTH && wr) ref_mem[addr[2:0]] = wdata;
    s.wr = wr; s.addr = addr; s.wdata = wdata; s.dly = dly; s.wait_cyc = e.wait_cyc;
    str_q.push_back(s);
    if (expect_rsp) exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_low_after_accept", cmd_ready, 0);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((cmd_ready !== 1'b1 || exp_q.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("idle_reached", cmd_ready, 1);
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready",  cmd_ready,  0);
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_read_en",    read_en,    0);
    check("rst_write_en",   write_en,   0);
    check("rst_address",    address,    0);
    check("rst_write_data", write_data, 0);
    check("rst_rsp_rdata",  rsp_rdata,  0);
    check("rst_rsp_status", rsp_status, 0);
  endtask

  // Register-file responder: reacts to strobes with the per-command latency.
  initial begin : responder
    logic [31:0]       rf_mem [RF_DEPTH];
    str_t              cur;
    int                pend, win;
    bit                strobe_prev;
    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    pend = 0; win = 0; strobe_prev = 1'b0;
    cap_wr = 1'b0; cap_addr = '0; cap_wdata = '0;
    for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = init_word(i);
    access_complete = 1'b0; read_data = '0; invalid_address = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      access_complete = 1'b0;
      read_data       = $urandom;
      invalid_address = 1'($urandom_range(0, 1));
      if (res) begin
        pend = 0; win = 0; strobe_prev = 1'b0;
      end else begin
        if (strobe_prev) begin
          check("strobe_one_cycle", {read_en, write_en}, 2'b00);
          strobe_prev = 1'b0;
        end
        if (win > 0) begin
          check("addr_stable", address, cur.addr);
          if (cur.wr) check("wdata_stable", write_data, cur.wdata);
          win--;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            access_complete = 1'b1;
            if (int'(cap_addr) >= RF_DEPTH) begin
              invalid_address = 1'b1;
            end else begin
              invalid_address = 1'b0;
              if (cap_wr) rf_mem[cap_addr[2:0]] = cap_wdata;
              else        read_data = rf_mem[cap_addr[2:0]];
            end
          end
        end
        if (read_en || write_en) begin
          check("strobe_exclusive", read_en & write_en, 0);
          check("strobe_expected", str_q.size() > 0, 1);
          if (str_q.size() > 0) begin
            cur = str_q.pop_front();
            check("strobe_type", {read_en, write_en}, cur.wr ? 2'b01 : 2'b10);
            check("strobe_addr", address, cur.addr);
            if (cur.wr) check("strobe_wdata", write_data, cur.wdata);
            cap_wr = write_en; cap_addr = address; cap_wdata = write_data;
            pend = cur.dly; win = cur.wait_cyc; strobe_prev = 1'b1;
            last_strobe_cyc = cyc;
          end
        end
        if (inject_stray) access_complete = 1'b1;
      end
    end
  end

  // Response monitor / scoreboard checker; also owns rsp_ready.
  initial begin : monitor
    exp_t cur;
    bit   open, bogus, handed;
    int   stall;
    open = 1'b0; bogus = 1'b0; handed = 1'b0; stall = 0;
    cur.status = '0; cur.rdata = '0; cur.wait_cyc = 0; cur.bp = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (res) begin
        open = 1'b0; handed = 1'b0; rsp_ready = 1'b0;
      end else begin
        if (handed) begin
          check("rsp_valid_drops_after_ready", rsp_valid, 0);
          open = 1'b0; handed = 1'b0;
        end
        if (rsp_valid) begin
          check("cmd_ready_low_in_rsp", cmd_ready, 0);
          if (!open) begin
            check("rsp_expected", exp_q.size() > 0, 1);
            open  = 1'b1;
            bogus = (exp_q.size() == 0);
            stall = 0;
            if (!bogus) begin
              cur = exp_q.pop_front();
              check("rsp_status",  rsp_status, cur.status);
              check("rsp_rdata",   rsp_rdata,  cur.rdata);
              check("rsp_latency", cyc - last_strobe_cyc, cur.wait_cyc + 1);
              stall = cur.bp;
            end
          end else if (!bogus) begin
            check("rsp_status_stable", rsp_status, cur.status);
            check("rsp_rdata_stable",  rsp_rdata,  cur.rdata);
          end
          if (stall > 0) begin
            stall--;
            rsp_ready = 1'b0;
          end else begin
            rsp_ready = 1'b1;
            handed    = 1'b1;
          end
        end else begin
          rsp_ready = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int r, dly, drained;
    res = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < RF_DEPTH; i++) ref_mem[i] = init_word(i);

    repeat (3) @(negedge clk);
    check_reset_values();
    res = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1);

    // Directed: read OK, write OK, read-back, invalid addresses.
    issue(1'b0, 8'd0, 32'h0,         1, 0, 1'b1);
    issue(1'b1, 8'd0, 32'hDEADBEEF,  1, 0, 1'b1);
    issue(1'b0, 8'd0, 32'h0,         2, 1, 1'b1);
    issue(1'b0, 8'd8, 32'h0,         1, 0, 1'b1);
    issue(1'b1, 8'd9, 32'hCAFE_F00D, 3, 0, 1'b1);
    // Timeout: silent, completion on the TIMEOUT-th cycle, completion one too late.
    issue(1'b0, 8'd3, 32'h0,         0,       0, 1'b1);
    issue(1'b0, 8'd3, 32'h0,         TMO,     0, 1'b1);
    issue(1'b1, 8'd5, 32'h0BAD_C0DE, TMO + 1, 0, 1'b1);
    // Backpressure: response withheld for 10 cycles.
    issue(1'b0, 8'd5, 32'h0,         1, 10, 1'b1);

    // Stray completion while idle must not produce a response.
    wait_idle();
    inject_stray = 1'b1;
    @(negedge clk);
    inject_stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_no_rsp",       rsp_valid, 0);
      check("stray_cmd_ready",    cmd_ready, 1);
    end

    // Reset during WAIT aborts the access with no response.
    issue(1'b0, 8'd2, 32'h5555_AAAA, 0, 0, 1'b0);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_mid_reset", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_abort", rsp_valid, 0);
    end
    issue(1'b0, 8'd2, 32'h0, 1, 0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      dly = 0;
      else if (r == 1) dly = TMO + 1;
      else             dly = int'($urandom_range(1, TMO));
      issue(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 11)), $urandom,
            dly, int'($urandom_range(0, 3)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    drained = 0;
    while (exp_q.size() != 0 && drained < 200) begin
      @(negedge clk);
      drained++;
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("strobes_drained",    str_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
